// File: rtl/cgra_config_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cgra_cfg_pkg
// Brief    : PE control-word layout, ALU/operand encodings and loader states.
// Revision : 1.0
// ============================================================================
package cgra_cfg_pkg;

    localparam int CTRL_W = 8;

    // Field positions inside one PE control word
    localparam int ALU_OP_LSB  = 0;
    localparam int ALU_OP_MSB  = 1;
    localparam int SEL_OP1_LSB = 2;
    localparam int SEL_OP1_MSB = 4;
    localparam int SEL_OP0_LSB = 5;
    localparam int SEL_OP0_MSB = 7;

    typedef enum logic [1:0] {
        ALU_OR  = 2'd0,
        ALU_AND = 2'd1,
        ALU_XOR = 2'd2,
        ALU_SHL = 2'd3
    } alu_op_e;

    typedef enum logic [2:0] {
        SEL_ZERO  = 3'd0,
        SEL_NORTH = 3'd1,
        SEL_EAST  = 3'd2,
        SEL_SOUTH = 3'd3,
        SEL_WEST  = 3'd4,
        SEL_SELF  = 3'd5,
        SEL_CONST = 3'd6,
        SEL_HOLD  = 3'd7
    } sel_op_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } loader_state_e;

    function automatic alu_op_e ctrl_alu_op(input logic [CTRL_W-1:0] word);
        return alu_op_e'(word[ALU_OP_MSB:ALU_OP_LSB]);
    endfunction

    function automatic sel_op_e ctrl_sel_op0(input logic [CTRL_W-1:0] word);
        return sel_op_e'(word[SEL_OP0_MSB:SEL_OP0_LSB]);
    endfunction

    function automatic sel_op_e ctrl_sel_op1(input logic [CTRL_W-1:0] word);
        return sel_op_e'(word[SEL_OP1_MSB:SEL_OP1_LSB]);
    endfunction

endpackage
`default_nettype wire

// File: rtl/cgra_config_loader_reg.sv
`default_nettype none
// ============================================================================
// Module   : cgra_config_loader_reg
// Brief    : Generic enabled register with synchronous active-high reset.
// Revision : 1.0
// ============================================================================
module cgra_config_loader_reg #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            data_q <= RESET_VAL;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule
`default_nettype wire

// File: rtl/cgra_config_loader.sv
`default_nettype none
// ============================================================================
// Module   : cgra_config_loader
// Brief    : Double-buffered PE configuration loader; shadow fill, 1-cycle commit.
// Revision : 1.0
// ============================================================================
module cgra_config_loader #(
    parameter int NUM_PE = 4,
    parameter int CTRL_W = cgra_cfg_pkg::CTRL_W
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         cfg_start,
    input  logic [CTRL_W-1:0]            cfg_data,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic                         run,
    output logic [NUM_PE*CTRL_W-1:0]     pe_ctrl,
    output logic                         pe_en,
    output logic                         configured,
    output logic                         busy,
    output logic [$clog2(NUM_PE):0]      load_idx
);

    import cgra_cfg_pkg::*;

    localparam int               IDX_W    = $clog2(NUM_PE) + 1;
    localparam int               BANK_W   = NUM_PE * CTRL_W;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PE - 1);

    loader_state_e      state_q, state_d;
    logic [IDX_W-1:0]   load_idx_q, load_idx_d;
    logic               configured_q;
    logic               xfer;
    logic               commit;
    logic [BANK_W-1:0]  shadow_flat;

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            load_idx_q   <= '0;
            configured_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            load_idx_q <= load_idx_d;
            if (commit) begin
                configured_q <= 1'b1;
            end
        end
    end

    // A restart in LOAD wins over a coincident transfer.
    always_comb begin
        state_d    = state_q;
        load_idx_d = load_idx_q;
        xfer       = 1'b0;
        commit     = 1'b0;
        cfg_ready  = 1'b0;
        busy       = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_start) begin
                    state_d    = ST_LOAD;
                    load_idx_d = '0;
                end
            end
            ST_LOAD: begin
                cfg_ready = 1'b1;
                busy      = 1'b1;
                if (cfg_start) begin
                    load_idx_d = '0;
                end else if (cfg_valid) begin
                    xfer       = 1'b1;
                    load_idx_d = load_idx_q + IDX_W'(1);
                    if (load_idx_q == LAST_IDX) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                busy       = 1'b1;
                commit     = 1'b1;
                load_idx_d = '0;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d    = ST_IDLE;
                load_idx_d = '0;
            end
        endcase
    end

    for (genvar i = 0; i < NUM_PE; i++) begin : g_shadow
        logic [CTRL_W-1:0] word_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                word_q <= '0;
            end else if (xfer && (load_idx_q == IDX_W'(i))) begin
                word_q <= cfg_data;
            end
        end

        assign shadow_flat[i*CTRL_W +: CTRL_W] = word_q;
    end

    cgra_config_loader_reg #(
        .WIDTH     (BANK_W),
        .RESET_VAL ('0)
    ) u_active_bank (
        .clock_i (clock),
        .reset_i (reset),
        .en_i    (commit),
        .d_i     (shadow_flat),
        .q_o     (pe_ctrl)
    );

    cgra_config_loader_reg #(
        .WIDTH     (1),
        .RESET_VAL (1'b0)
    ) u_pe_en (
        .clock_i (clock),
        .reset_i (reset),
        .en_i    (1'b1),
        .d_i     (run & configured_q),
        .q_o     (pe_en)
    );

    assign configured = configured_q;
    assign load_idx   = load_idx_q;

endmodule
`default_nettype wire
